// File: rtl/contador_varredura_display.sv
// Scan sequencer for a 4-position seven-segment display: steps the position select at a
// prescaled rate and blanks every anode for APAGAR cycles around each select change.
module contador_varredura_display #(
  parameter int unsigned DIVISOR = 50000,
  parameter int unsigned APAGAR  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       reiniciar,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] anodo,
  output logic       apagado,
  output logic       fim_ciclo
);

  localparam int unsigned PresW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(DIVISOR - 1);
  localparam logic [7:0] ApagMax = 8'(APAGAR - 1);

  typedef enum logic [1:0] {
    StApagando,
    StAceso,
    StParado
  } state_e;

  state_e           state_q;
  logic [1:0]       pos_q;
  logic [PresW-1:0] cnt_pres_q;
  logic [7:0]       cnt_apag_q;
  logic [3:0]       anodo_q;
  logic             apagado_q;
  logic             fim_q;

  function automatic logic [3:0] anodo_de(input logic [1:0] p);
    return ~(4'b0001 << p);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StApagando;
      pos_q      <= 2'd0;
      cnt_pres_q <= '0;
      cnt_apag_q <= '0;
      anodo_q    <= 4'b1111;
      apagado_q  <= 1'b1;
      fim_q      <= 1'b0;
    end else if (reiniciar) begin
      // Restart cancels any pending wrap, so no fim_ciclo pulse here.
      state_q    <= habilitar ? StApagando : StParado;
      pos_q      <= 2'd0;
      cnt_pres_q <= '0;
      cnt_apag_q <= '0;
      anodo_q    <= 4'b1111;
      apagado_q  <= 1'b1;
      fim_q      <= 1'b0;
    end else if (!habilitar) begin
      state_q    <= StParado;
      cnt_pres_q <= '0;
      cnt_apag_q <= '0;
      anodo_q    <= 4'b1111;
      apagado_q  <= 1'b1;
      fim_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StApagando: begin
          fim_q <= 1'b0;
          if (cnt_apag_q == ApagMax) begin
            state_q    <= StAceso;
            cnt_apag_q <= '0;
            cnt_pres_q <= '0;
            anodo_q    <= anodo_de(pos_q);
            apagado_q  <= 1'b0;
          end else begin
            cnt_apag_q <= cnt_apag_q + 8'd1;
          end
        end
        StAceso: begin
          if (cnt_pres_q == PresMax) begin
            // Select moves only as the anodes go dark, so the decoder never shows ghosts.
            state_q    <= StApagando;
            pos_q      <= pos_q + 2'd1;
            cnt_pres_q <= '0;
            cnt_apag_q <= '0;
            anodo_q    <= 4'b1111;
            apagado_q  <= 1'b1;
            fim_q      <= (pos_q == 2'd3);
          end else begin
            cnt_pres_q <= cnt_pres_q + PresW'(1);
            fim_q      <= 1'b0;
          end
        end
        StParado: begin
          state_q    <= StApagando;
          cnt_pres_q <= '0;
          cnt_apag_q <= '0;
          anodo_q    <= 4'b1111;
          apagado_q  <= 1'b1;
          fim_q      <= 1'b0;
        end
        default: begin
          state_q    <= StApagando;
          cnt_pres_q <= '0;
          cnt_apag_q <= '0;
          anodo_q    <= 4'b1111;
          apagado_q  <= 1'b1;
          fim_q      <= 1'b0;
        end
      endcase
    end
  end

  assign saida1Contador = pos_q[1];
  assign saida2Contador = pos_q[0];
  assign anodo          = anodo_q;
  assign apagado        = apagado_q;
  assign fim_ciclo      = fim_q;

endmodule

// File: tb/tb_contador_varredura_display.sv
// Scoreboard bench for contador_varredura_display with DIVISOR=4, APAGAR=2: the driver queues
// hand-derived per-cycle expectations, the monitor pops and compares one per clock.
module tb_contador_varredura_display;

  logic       clk;
  logic       reset;
  logic       habilitar;
  logic       reiniciar;
  logic       saida1Contador;
  logic       saida2Contador;
  logic [3:0] anodo;
  logic       apagado;
  logic       fim_ciclo;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic       apg;
    logic       fim;
    logic [7:0] test;
    logic [7:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_vec;
  int   n_miss;
  logic [7:0] test_id;
  logic [7:0] vec_idx;

  logic [3:0] an_lut [4];

  contador_varredura_display #(
    .DIVISOR(4),
    .APAGAR (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .habilitar     (habilitar),
    .reiniciar     (reiniciar),
    .saida1Contador(saida1Contador),
    .saida2Contador(saida2Contador),
    .anodo         (anodo),
    .apagado       (apagado),
    .fim_ciclo     (fim_ciclo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      n_vec++;
      if ({saida1Contador, saida2Contador, anodo, apagado, fim_ciclo} !==
          {e_mon.sel, e_mon.an, e_mon.apg, e_mon.fim}) begin
        n_miss++;
        $display("FAIL outputs test%0d vec%0d: got sel=%b%b anodo=%b apagado=%b fim=%b, want sel=%b anodo=%b apagado=%b fim=%b",
                 e_mon.test, e_mon.idx, saida1Contador, saida2Contador, anodo, apagado,
                 fim_ciclo, e_mon.sel, e_mon.an, e_mon.apg, e_mon.fim);
      end
      if (!(anodo === 4'b1111 || anodo === an_lut[{saida1Contador, saida2Contador}])) begin
        n_miss++;
        $display("FAIL invariant test%0d vec%0d: got anodo=%b with sel=%b%b, want 1111 or %b",
                 e_mon.test, e_mon.idx, anodo, saida1Contador, saida2Contador,
                 an_lut[{saida1Contador, saida2Contador}]);
      end
    end
  end

  task automatic drive(input logic r, input logic h, input logic c, input logic [1:0] sel,
                       input logic [3:0] an, input logic apg, input logic fim);
    exp_t e;
    @(negedge clk);
    reset     = r;
    habilitar = h;
    reiniciar = c;
    e.sel  = sel;
    e.an   = an;
    e.apg  = apg;
    e.fim  = fim;
    e.test = test_id;
    e.idx  = vec_idx;
    vec_idx = vec_idx + 8'd1;
    exp_q.push_back(e);
  endtask

  task automatic blank(input int n, input logic [1:0] sel);
    repeat (n) drive(1'b0, 1'b1, 1'b0, sel, 4'b1111, 1'b1, 1'b0);
  endtask

  task automatic lit(input int n, input logic [1:0] sel);
    repeat (n) drive(1'b0, 1'b1, 1'b0, sel, an_lut[sel], 1'b0, 1'b0);
  endtask

  task automatic start_test(input logic [7:0] t);
    test_id = t;
    vec_idx = 8'd0;
  endtask

  initial begin
    an_lut[0] = 4'b1110;
    an_lut[1] = 4'b1101;
    an_lut[2] = 4'b1011;
    an_lut[3] = 4'b0111;
    n_vec     = 0;
    n_miss    = 0;
    reset     = 1'b1;
    habilitar = 1'b0;
    reiniciar = 1'b0;

    // 1: reset then idle in PARADO
    start_test(8'd1);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0);

    // 2: free-running scan, wrap pulse in first blank cycle after position 3
    start_test(8'd2);
    blank(2, 2'd0); lit(4, 2'd0);
    blank(2, 2'd1); lit(4, 2'd1);
    blank(2, 2'd2); lit(4, 2'd2);
    blank(2, 2'd3); lit(4, 2'd3);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b1);
    blank(1, 2'd0); lit(4, 2'd0);

    // 3: drop habilitar on 2nd lit cycle of position 2, then resume
    blank(2, 2'd1); lit(4, 2'd1);
    blank(2, 2'd2); lit(2, 2'd2);
    start_test(8'd3);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 1'b0);
    blank(2, 2'd2); lit(4, 2'd2);

    // 4: reiniciar on last lit cycle of position 3 suppresses the wrap pulse
    blank(2, 2'd3); lit(4, 2'd3);
    start_test(8'd4);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b0);
    blank(1, 2'd0); lit(4, 2'd0);

    // 5: reiniciar with habilitar low at position 1
    blank(2, 2'd1); lit(1, 2'd1);
    start_test(8'd5);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0);
    blank(2, 2'd0); lit(4, 2'd0);

    // 7: reiniciar held several cycles keeps the blank counter at zero
    blank(2, 2'd1); lit(2, 2'd1);
    start_test(8'd7);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b0);
    blank(1, 2'd0); lit(4, 2'd0);

    // 6: reset while lit at position 2
    blank(2, 2'd1); lit(4, 2'd1);
    blank(2, 2'd2); lit(2, 2'd2);
    start_test(8'd6);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0);
    blank(1, 2'd0); lit(2, 2'd0);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/contador_varredura_display.md
Name: contador_varredura_display

Overview:
- Scan sequencer directly upstream of the S3 seven-segment letter decoder.
- Produces the 2-bit position select (saida1Contador = MSB, saida2Contador = LSB) that the decoder turns into segments a..g, plus the active-low digit anode strobes.
- Cycles through 4 display positions at a prescaled rate.
- Blanks all anodes for a short dead time around every select change so the decoder output settles without ghosting.
- Supports enable/disable and a restart-to-position-0 on a new selection from the machine controller.

Parameters:
- DIVISOR, 50000, clock cycles each position stays lit; legal range 2..2^20.
- APAGAR, 4, blanking cycles inserted before each lit interval; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- habilitar  input  1  scan enable; level-sensitive.
- reiniciar  input  1  synchronous restart pulse; forces position 0.
- saida1Contador  output  1  position select MSB to the decoder.
- saida2Contador  output  1  position select LSB to the decoder.
- anodo  output  4  active-low digit enables; bit i = position i.
- apagado  output  1  high while all anodes are forced off.
- fim_ciclo  output  1  one-cycle pulse on position wrap 3->0.

Behaviour:
- All outputs are registered. There is one clock; reset is synchronous and active-high.
- Reset values: pos=00, so saida1Contador=0 and saida2Contador=0; anodo=4'b1111; apagado=1; fim_ciclo=0; state=APAGANDO; both counters 0.
- Internal state:
  - pos, 2 bits.
  - cnt_pres, width ceil(log2(DIVISOR)).
  - cnt_apag, 8 bits.
  - FSM states {APAGANDO, ACESO, PARADO}.
- Priority per edge: reset > reiniciar > habilitar=0 > normal operation.
- APAGANDO:
  - anodo=1111, apagado=1.
  - cnt_apag increments each cycle.
  - On the edge where cnt_apag==APAGAR-1: go to ACESO, clear cnt_apag and cnt_pres.
  - The state lasts exactly APAGAR cycles.
- ACESO:
  - anodo has bit pos=0 and all others 1; apagado=0.
  - cnt_pres increments each cycle.
  - On the edge where cnt_pres==DIVISOR-1:
    - pos <= pos+1 (mod 4, 11 wraps to 00).
    - Go to APAGANDO.
    - Assert fim_ciclo for exactly that one following cycle, only if the old pos was 11.
  - The state lasts exactly DIVISOR cycles.
- Select outputs change only on entry to APAGANDO, never while an anode is low.
- Period per position = APAGAR + DIVISOR cycles; full scan = 4*(APAGAR+DIVISOR).
- habilitar=0 (any state):
  - Next state PARADO: anodo=1111, apagado=1.
  - pos held; counters cleared; fim_ciclo=0.
- PARADO with habilitar=1: go to APAGANDO (full APAGAR blank), then resume at the held pos with a full DIVISOR lit interval.
- reiniciar=1 (any state, not in reset):
  - pos <= 00; counters cleared; fim_ciclo=0. A wrap interrupted by reiniciar does not pulse.
  - Next state is APAGANDO if habilitar=1, else PARADO.
- reiniciar held high for multiple cycles: stays in APAGANDO/PARADO with pos=00 and cnt_apag=0. Blanking restarts only after release.
- Reset mid-operation: reset values appear on the next edge regardless of state; no partial pulse on fim_ciclo.
- Invariants:
  - anodo is always 1111 or exactly one bit low.
  - The low bit index always equals {saida1Contador, saida2Contador}.

Test Plan (DIVISOR=4, APAGAR=2):
1. Hold reset 3 cycles, then release with habilitar=0 -> select=00, anodo=1111, apagado=1, fim_ciclo=0, held indefinitely (PARADO).
2. habilitar=1 continuously, 30 cycles:
   - Expected per position: 2 blank cycles, then 4 cycles with anodo 1110, 1101, 1011, 0111 in turn.
   - Select follows 00, 01, 10, 11, 00.
   - fim_ciclo pulses once per 24-cycle period, in the first blank cycle after pos 11.
3. Drop habilitar during the 2nd lit cycle of pos 10 -> next cycle anodo=1111, select stays 10. Re-raise habilitar -> 2 blank cycles, then anodo=1011 for a full 4 cycles.
4. Pulse reiniciar on the last lit cycle of pos 11 -> select=00, fim_ciclo stays 0, 2 blank cycles, then anodo=1110.
5. reiniciar=1 and habilitar=0 in the same cycle while at pos 01 -> select=00, anodo=1111, PARADO. habilitar=1 later -> 2 blank cycles, then anodo=1110.
6. Assert reset while lit at pos 10 -> next edge select=00, anodo=1111, apagado=1. Check the anodo one-hot/select invariant on every cycle of all tests.
